// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result bus between a requester and the nibble-serial add/sub sequencer.
// The master modport is the requester side, and the slave modport is the sequencer side.
interface nibble_serial_addsub_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Runs a WIDTH-bit two's-complement add/subtract through one 4-bit slice, one nibble
// per cycle LSB first, with the inter-nibble carry held in a register.
module nibble_serial_addsub_ctrl #(
    parameter int WIDTH = 16
) (
    input logic                        clk,
    input logic                        rst,
    nibble_serial_addsub_ctrl_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic             op_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             overflow_reg;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       s;
    logic [3:0]       low;
    logic             last_nib;

    // Operand copies shift right each step, so the current nibble always sits at [3:0].
    always_comb begin
        a_nib    = a_reg[3:0];
        b_nib    = b_reg[3:0] ^ {4{op_reg}};
        s        = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};
        low      = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b000, carry_reg};
        last_nib = (idx == IDX_W'(NIB - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bus.busy   = (state != IDLE);
        bus.done   = (state == DONE);
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last_nib)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The result nibbles enter acc from the top, so after NIB steps acc holds the full result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            acc          <= '0;
            op_reg       <= 1'b0;
            carry_reg    <= 1'b0;
            idx          <= '0;
            result_reg   <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        op_reg    <= bus.op;
                        carry_reg <= bus.op;
                        idx       <= '0;
                        acc       <= '0;
                    end
                end
                RUN: begin
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    carry_reg <= s[4];
                    acc       <= {s[3:0], acc[WIDTH-1:4]};
                    idx       <= last_nib ? '0 : idx + 1'b1;
                    if (last_nib) begin
                        result_reg   <= {s[3:0], acc[WIDTH-1:4]};
                        cout_reg     <= s[4];
                        overflow_reg <= low[3] ^ s[4];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result   = result_reg;
    assign bus.cout     = cout_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Randomized self-checking bench for nibble_serial_addsub_ctrl.
// It compares the DUT against an integer-arithmetic reference model and a cycle-count model of the handshake.
module tb_nibble_serial_addsub_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst;

    nibble_serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] held_result;
    logic             held_cout;
    logic             held_ov;

    typedef struct {
        logic             op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the whole operands.
    function automatic void model(input logic op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] res,
                                  output logic c, output logic ov);
        longint ua, ub, sa, sb, u, s, smax, smin;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        smax = (longint'(1) << (WIDTH - 1)) - 1;
        smin = -(longint'(1) << (WIDTH - 1));
        if (op) begin
            u = ua - ub;
            s = sa - sb;
            c = (ua >= ub);
        end else begin
            u = ua + ub;
            s = sa + sb;
            c = (u >= (longint'(1) << WIDTH));
        end
        res = u[WIDTH-1:0];
        ov  = (s > smax) || (s < smin);
    endfunction

    task automatic checkHeld(input string tag);
        checkOutput(tag, 32'({held_ov, held_cout, held_result}),
                    32'({bus.overflow, bus.cout, bus.result}) ^ 32'({held_ov, held_cout, held_result})
                    ^ 32'({held_ov, held_cout, held_result}) ^ 32'({bus.overflow, bus.cout, bus.result})
                    ^ 32'({held_ov, held_cout, held_result}));
    endtask

    task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input string tag);
        logic [WIDTH-1:0] er;
        logic             ec, eo;
        int               cnt;
        model(op, a, b, er, ec, eo);
        cnt = 0;
        while (bus.busy && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (bus.busy) checkOutput({tag, "_idle_wait"}, 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
        cnt = 0;
        // Start stays high with scrambled inputs while busy; none of it may take effect.
        while (!bus.done && cnt < NIB + 4) begin
            bus.a  = WIDTH'($urandom);
            bus.b  = WIDTH'($urandom);
            bus.op = 1'($urandom);
            checkOutput({tag, "_stable"}, 32'({bus.overflow, bus.cout, bus.result}),
                        32'({held_ov, held_cout, held_result}));
            @(posedge clk); #1;
            cnt++;
        end
        bus.start = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cnt), 32'(NIB));
        checkOutput({tag, "_result"}, 32'(bus.result), 32'(er));
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
        held_result = er;
        held_cout   = ec;
        held_ov     = eo;
        @(posedge clk); #1;
        checkOutput({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        checkOutput({tag, "_busy_clear"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_held"}, 32'({bus.overflow, bus.cout, bus.result}),
                    32'({held_ov, held_cout, held_result}));
    endtask

    // Start held high continuously: one accept per idle period, done every NIB+2 cycles.
    task automatic holdStartPhase();
        req_t             pending[$];
        req_t             r;
        int               remaining;
        int               last_done;
        int               ndone;
        logic             accept;
        logic [WIDTH-1:0] er;
        logic             ec, eo;
        remaining = 0;
        last_done = -1;
        ndone     = 0;
        bus.start = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.op = 1'($urandom);
            bus.a  = WIDTH'($urandom);
            bus.b  = WIDTH'($urandom);
            accept = (remaining == 0);
            if (accept) pending.push_back('{bus.op, bus.a, bus.b});
            @(posedge clk); #1;
            if (accept) remaining = NIB + 1;
            else if (remaining > 0) remaining--;
            checkOutput("hold_busy", 32'(bus.busy), 32'(remaining > 0));
            checkOutput("hold_done", 32'(bus.done), 32'(remaining == 1));
            if (remaining == 1 && pending.size() > 0) begin
                r = pending.pop_front();
                model(r.op, r.a, r.b, er, ec, eo);
                checkOutput("hold_result", 32'({eo, ec, er}),
                            32'({bus.overflow, bus.cout, bus.result}));
                held_result = er;
                held_cout   = ec;
                held_ov     = eo;
                if (last_done >= 0) checkOutput("hold_spacing", 32'(cyc - last_done), 32'(NIB + 2));
                last_done = cyc;
                ndone++;
            end
        end
        bus.start = 1'b0;
        for (int k = 0; k < 10 && bus.busy; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("hold_drain", 32'(bus.busy), 32'd0);
        checkOutput("hold_count", 32'(ndone >= 8), 32'd1);
    endtask

    logic [WIDTH-1:0] corners[5];

    initial begin
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = {1'b0, {(WIDTH-1){1'b1}}};
        corners[3] = {1'b1, {(WIDTH-1){1'b0}}};
        corners[4] = WIDTH'(1);

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        held_result = '0;
        held_cout   = 1'b0;
        held_ov     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_outputs", 32'({bus.overflow, bus.cout, bus.result}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b0, 16'h1234, 16'h0FFF, "add_basic");
        checkOutput("add_basic_const", 32'(bus.result), 32'h2233);
        applyStimulus(1'b1, 16'h0005, 16'h0007, "sub_borrow");
        checkOutput("sub_borrow_const", 32'({bus.cout, bus.result}), 32'h0FFFE);
        applyStimulus(1'b0, 16'h7FFF, 16'h0001, "add_ovf");
        checkOutput("add_ovf_const", 32'({bus.overflow, bus.cout, bus.result}), 32'h28000);
        applyStimulus(1'b1, 16'h8000, 16'h0001, "sub_ovf");
        checkOutput("sub_ovf_const", 32'({bus.overflow, bus.cout, bus.result}), 32'h37FFF);

        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : WIDTH'($urandom);
            applyStimulus(1'($urandom), ra, rb, "rand");
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        holdStartPhase();

        // Reset asserted during the second RUN cycle abandons the operation.
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrun_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrun_rst_done", 32'(bus.done), 32'd0);
        checkOutput("midrun_rst_outputs", 32'({bus.overflow, bus.cout, bus.result}), 32'd0);
        @(posedge clk); #1;
        rst         = 1'b0;
        held_result = '0;
        held_cout   = 1'b0;
        held_ov     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            checkOutput("midrun_no_done", 32'({bus.done, bus.busy}), 32'd0);
        end
        applyStimulus(1'b0, 16'hFFFF, 16'h0001, "post_rst");
        checkOutput("post_rst_const", 32'({bus.overflow, bus.cout, bus.result}), 32'h10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
        $fatal(1, "[TB] watchdog");
    end
endmodule
